// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock lock monitor: FSM state encodings,
// status-word bit positions and the status-word packing helper.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } clk_state_t;

  localparam int unsigned HOLD_CYCLES = 4;

  localparam int unsigned STAT_LOCKED_BIT  = 0;
  localparam int unsigned STAT_CLK_OK_BIT  = 1;
  localparam int unsigned STAT_STATE_LSB   = 2;
  localparam int unsigned STAT_TIMEOUT_BIT = 4;
  localparam int unsigned STAT_GLITCH_LSB  = 8;
  localparam int unsigned STAT_LOSS_LSB    = 16;

  localparam int unsigned CTRL_CLEAR_BIT = 0;
  localparam int unsigned CTRL_HOLD_BIT  = 1;

  function automatic logic [31:0] pack_status(
    input logic [15:0] loss_cnt,
    input logic [7:0]  glitch_cnt,
    input logic        timeout,
    input clk_state_t  state,
    input logic        clk_ok,
    input logic        locked_s
  );
    logic [31:0] w;
    w                            = '0;
    w[STAT_LOSS_LSB +: 16]       = loss_cnt;
    w[STAT_GLITCH_LSB +: 8]      = glitch_cnt;
    w[STAT_TIMEOUT_BIT]          = timeout;
    w[STAT_STATE_LSB +: 2]       = state;
    w[STAT_CLK_OK_BIT]           = clk_ok;
    w[STAT_LOCKED_BIT]           = locked_s;
    return w;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the local clock
// domain; both flops clear on synchronous reset.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/clock_lock_monitor.sv
// PLL lock supervisor: sequences release of the generated-clock reset after a
// settled lock, tracks glitches/losses/timeouts and exposes them on a local bus.
module clock_lock_monitor
  import clk_mon_pkg::*;
#(
  parameter logic [7:0]  ADDR          = 8'hC4,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1024,
  parameter logic [3:0]  DEBOUNCE      = 4'd8,
  parameter logic [23:0] TIMEOUT       = 24'd1000000
) (
  input  logic        MCLK,
  input  logic        rst,
  input  logic        locked,
  input  logic [31:0] DataIn,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] DataOut,
  output logic        ack,
  output logic        sys_rst,
  output logic        clk_ok
);

  logic        w_locked_s;
  logic        w_sel;
  logic        w_wr;
  logic        w_unused_data;

  clk_state_t  r_state;
  logic [1:0]  r_hold_cnt;
  logic [23:0] r_to_cnt;
  logic [15:0] r_settle_cnt;
  logic [3:0]  r_low_cnt;
  logic [15:0] r_loss_cnt;
  logic [7:0]  r_glitch_cnt;
  logic        r_timeout;
  logic        r_ack;
  logic        r_sys_rst;
  logic        r_clk_ok;

  sync2 u_sync2 (
    .i_clk (MCLK),
    .i_rst (rst),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  assign w_sel         = (Address == ADDR);
  assign w_wr          = w_sel && Write;
  assign w_unused_data = ^DataIn[31:2];

  always_ff @(posedge MCLK) begin
    if (rst) begin
      r_state      <= ST_HOLD;
      r_hold_cnt   <= '0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
      r_low_cnt    <= '0;
      r_loss_cnt   <= '0;
      r_glitch_cnt <= '0;
      r_timeout    <= 1'b0;
      r_ack        <= 1'b0;
      r_sys_rst    <= 1'b1;
      r_clk_ok     <= 1'b0;
    end else begin
      r_ack     <= w_sel && (Read || Write);
      r_sys_rst <= (r_state != ST_RUN);
      r_clk_ok  <= (r_state == ST_RUN);

      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == 2'(HOLD_CYCLES - 1)) begin
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
            r_state    <= ST_WAIT_LOCK;
          end else begin
            r_hold_cnt <= r_hold_cnt + 2'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_settle_cnt <= '0;
            r_state      <= ST_SETTLE;
          end else if (r_to_cnt == TIMEOUT - 24'd1) begin
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 24'd1;
          end
        end
        ST_SETTLE: begin
          if (!w_locked_s) begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_LOCK;
          end else if (r_settle_cnt == SETTLE_CYCLES - 16'd1) begin
            r_low_cnt <= '0;
            r_state   <= ST_RUN;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            if (r_low_cnt == DEBOUNCE - 4'd1) begin
              r_low_cnt <= '0;
              r_to_cnt  <= '0;
              r_state   <= ST_WAIT_LOCK;
              if (r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + 16'd1;
            end else begin
              r_low_cnt <= r_low_cnt + 4'd1;
            end
          end else if (r_low_cnt != '0) begin
            // A low run shorter than DEBOUNCE ended: count it once, on recovery.
            r_low_cnt <= '0;
            if (r_glitch_cnt != '1) r_glitch_cnt <= r_glitch_cnt + 8'd1;
          end
        end
        default: r_state <= ST_HOLD;
      endcase

      // Bus control is applied last so it overrides same-cycle updates above.
      if (w_wr && DataIn[CTRL_CLEAR_BIT]) begin
        r_loss_cnt   <= '0;
        r_glitch_cnt <= '0;
        r_timeout    <= 1'b0;
      end
      if (w_wr && DataIn[CTRL_HOLD_BIT]) begin
        r_hold_cnt <= '0;
        r_low_cnt  <= '0;
        r_state    <= ST_HOLD;
      end
    end
  end

  always_comb begin
    DataOut = '0;
    if (Read && w_sel)
      DataOut = pack_status(r_loss_cnt, r_glitch_cnt, r_timeout, r_state,
                            r_clk_ok, w_locked_s);
  end

  assign ack     = r_ack;
  assign sys_rst = r_sys_rst;
  assign clk_ok  = r_clk_ok;

endmodule

// File: tb/tb_clock_lock_monitor.sv
// Directed bench for clock_lock_monitor with short settle/debounce/timeout.
module tb_clock_lock_monitor;

  logic        MCLK;
  logic        rst;
  logic        locked;
  logic [31:0] DataIn;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic        ack;
  logic        sys_rst;
  logic        clk_ok;

  int total;
  int bad;

  clock_lock_monitor #(
    .ADDR          (8'hC4),
    .SETTLE_CYCLES (16'd16),
    .DEBOUNCE      (4'd4),
    .TIMEOUT       (24'd64)
  ) dut (
    .MCLK    (MCLK),
    .rst     (rst),
    .locked  (locked),
    .DataIn  (DataIn),
    .Address (Address),
    .Read    (Read),
    .Write   (Write),
    .DataOut (DataOut),
    .ack     (ack),
    .sys_rst (sys_rst),
    .clk_ok  (clk_ok)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // Combinational status read placed between clock edges; no ack results.
  task automatic read_status(output logic [31:0] v);
    Address = 8'hC4;
    Read    = 1'b1;
    #1;
    v       = DataOut;
    Read    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; locked = 1'b1; Read = 1'b0; Write = 1'b0;
    Address = 8'h00; DataIn = '0;
    repeat (3) @(negedge MCLK);
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL reset_sys_rst got=%b exp=1", sys_rst); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL reset_clk_ok got=%b exp=0", clk_ok); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    read_status(v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=00000000", v); end
  endtask

  task automatic test_lock_up();
    int n;
    logic prev_sys;
    logic [31:0] v;
    rst = 1'b0;
    n = 0;
    prev_sys = 1'b0;
    while (n < 60) begin
      @(negedge MCLK);
      n++;
      if (clk_ok === 1'b1) break;
      prev_sys = sys_rst;
    end
    total++; if (clk_ok !== 1'b1) begin bad++; $display("FAIL lockup_clk_ok got=%b exp=1 within 60", clk_ok); end
    total++; if (n < 22 || n > 24) begin bad++; $display("FAIL lockup_latency got=%0d exp=22..24", n); end
    total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL lockup_sys_rst got=%b exp=0", sys_rst); end
    total++; if (prev_sys !== 1'b1) begin bad++; $display("FAIL lockup_sys_rst_before got=%b exp=1", prev_sys); end
    read_status(v);
    total++; if (v !== 32'h0000_000F) begin bad++; $display("FAIL lockup_status got=%h exp=0000000f", v); end
  endtask

  task automatic test_glitch();
    int drops;
    logic [31:0] v;
    locked = 1'b0;
    repeat (2) @(negedge MCLK);
    locked = 1'b1;
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge MCLK);
      if (clk_ok !== 1'b1) drops++;
    end
    total++; if (drops != 0) begin bad++; $display("FAIL glitch_clk_ok_drops got=%0d exp=0", drops); end
    read_status(v);
    total++; if (v !== 32'h0000_010F) begin bad++; $display("FAIL glitch_status got=%h exp=0000010f", v); end
  endtask

  task automatic test_loss();
    int n;
    int sysbad;
    logic [31:0] v;
    locked = 1'b0;
    repeat (10) @(negedge MCLK);
    read_status(v);
    total++; if (v !== 32'h0001_0104) begin bad++; $display("FAIL loss_status got=%h exp=00010104", v); end
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL loss_sys_rst got=%b exp=1", sys_rst); end
    locked = 1'b1;
    n = 0;
    sysbad = 0;
    while (n < 40) begin
      @(negedge MCLK);
      n++;
      if (clk_ok === 1'b1) break;
      if (sys_rst !== 1'b1) sysbad++;
    end
    total++; if (clk_ok !== 1'b1) begin bad++; $display("FAIL loss_relock got=%b exp=1 within 40", clk_ok); end
    total++; if (n < 19 || n > 21) begin bad++; $display("FAIL loss_relock_latency got=%0d exp=19..21", n); end
    total++; if (sysbad != 0) begin bad++; $display("FAIL loss_sys_rst_held got=%0d exp=0 drops", sysbad); end
  endtask

  task automatic test_clear_on_loss();
    logic [31:0] v;
    locked = 1'b0;
    repeat (5) @(negedge MCLK);
    Address = 8'hC4; DataIn = 32'd3; Write = 1'b1;
    @(negedge MCLK);
    Write = 1'b0; DataIn = '0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL clr_ack got=%b exp=1", ack); end
    read_status(v);
    total++; if (v[31:16] !== 16'h0) begin bad++; $display("FAIL clr_loss got=%h exp=0000", v[31:16]); end
    total++; if (v[15:8] !== 8'h0) begin bad++; $display("FAIL clr_glitch got=%h exp=00", v[15:8]); end
    total++; if (v[3:2] !== 2'd0) begin bad++; $display("FAIL clr_state got=%0d exp=0", v[3:2]); end
    @(negedge MCLK);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL clr_ack_one_cycle got=%b exp=0", ack); end
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL clr_sys_rst got=%b exp=1", sys_rst); end
  endtask

  task automatic test_bad_addr();
    Address = 8'hC3; Read = 1'b1;
    #1;
    total++; if (DataOut !== 32'h0) begin bad++; $display("FAIL badaddr_data got=%h exp=00000000", DataOut); end
    @(negedge MCLK);
    Read = 1'b0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL badaddr_ack got=%b exp=0", ack); end
    Address = 8'hC4; Read = 1'b1;
    @(negedge MCLK);
    Read = 1'b0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL read_ack got=%b exp=1", ack); end
    @(negedge MCLK);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_ack_one_cycle got=%b exp=0", ack); end
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    rst = 1'b1; locked = 1'b0;
    repeat (2) @(negedge MCLK);
    rst = 1'b0;
    repeat (67) @(negedge MCLK);
    read_status(v);
    total++; if (v[4] !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", v[4]); end
    @(negedge MCLK);
    read_status(v);
    total++; if (v !== 32'h0000_0014) begin bad++; $display("FAIL timeout_status got=%h exp=00000014", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    rst = 1'b1; Address = 8'hC4; DataIn = 32'd2; Write = 1'b1;
    @(negedge MCLK);
    Write = 1'b0; DataIn = '0;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b exp=0", ack); end
    total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL midrst_sys_rst got=%b exp=1", sys_rst); end
    total++; if (clk_ok !== 1'b0) begin bad++; $display("FAIL midrst_clk_ok got=%b exp=0", clk_ok); end
    read_status(v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midrst_status got=%h exp=00000000", v); end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lock_up();
    test_glitch();
    test_loss();
    test_clear_on_loss();
    test_bad_addr();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
